noc_output_arbiter: RTL and testbench
=====================================

Name: noc_output_arbiter

Overview:
- Per-output-port scheduler for the mesh/ring router.
- Shares one outgoing channel (cw, ccw, ns, sn or PE) among NUM_REQ input-side requesters using polarity-phased round-robin arbitration.
- Holds one single-entry output buffer per virtual channel (VC0/VC1).
- Drives the downstream send/ready/data handshake used by router and NIC links (so/ro/do).

Parameters:
- NUM_REQ, 4, number of requesting input channels (>=2).
- PACKET_WIDTH, 64, packet width in bits.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- polarity  in  1  router polarity phase (router's polarity_out); p = polarity.
- req  in  NUM_REQ  request i holds a valid packet on req_data slice i.
- req_data  in  NUM_REQ*PACKET_WIDTH  packet i occupies bits [i*PACKET_WIDTH +: PACKET_WIDTH].
- gnt  out  NUM_REQ  one-hot, combinational; packet i is captured at this rising edge; requester drops it.
- ro  in  1  downstream ready (downstream buffer for the VC being drained has space).
- so  out  1  registered send strobe, one cycle per packet.
- do  out  PACKET_WIDTH  registered packet data, valid while so=1.

Behaviour:
- Packet VC = req_data bit PACKET_WIDTH-1 (MSB).
  - 64'h200200000000FA50 -> VC0.
  - 64'hA00200000000FA50 -> VC1.
- State: buf_full[1:0], buf_data[1:0], rr_ptr (log2 NUM_REQ bits), so, do.
- Reset (reset=0, async):
  - buf_full=0, rr_ptr=NUM_REQ-1 (index 0 wins first), so=0, do=0.
  - gnt=0 while reset low.
  - Buffered packets are discarded; in-flight so drops immediately.
- Fill phase, buffer p:
  - eligible[i] = req[i] & (VC_i==p) & ~buf_full[p].
  - Grant the first eligible index after rr_ptr, searching circularly: rr_ptr+1 .. NUM_REQ-1, 0 .. rr_ptr.
  - On grant: gnt[i]=1 combinationally; at the edge, buf_data[p]<=packet, buf_full[p]<=1, rr_ptr<=i.
  - No eligible requester: gnt=0, rr_ptr unchanged.
  - Requests with VC!=p are never granted this cycle and simply wait.
- Drain phase, buffer ~p:
  - If buf_full[~p] & ro at the edge: so<=1, do<=buf_data[~p], buf_full[~p]<=0.
  - Otherwise so<=0 and do holds its last value.
- Fill and drain always hit opposite buffers in the same cycle, so there is no read/write collision.
- Latency: granted at edge k (polarity p) -> so=1 after edge k+1 if polarity toggled and ro=1. Minimum 1 cycle; one packet per cycle sustained when both VCs are loaded.
- Backpressure: ro=0 holds buf_full[~p]. That buffer blocks further grants on its VC only; the other VC is unaffected.
- polarity held constant (not toggling): the fill VC keeps filling only once (buffer stays full); the drain VC keeps draining. No deadlock inside the block.
- gnt must be 0 for every index whose req=0.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs pkt_cnt[15:0] and stall_cnt[15:0], both cleared by reset, both saturating at 16'hFFFF.
  - pkt_cnt increments on every so=1 launch.
  - stall_cnt increments on each edge where buf_full[~p]=1 and ro=0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg:
  - PACKET_WIDTH default 64.
  - VC_BIT = PACKET_WIDTH-1.
  - VC0/VC1 localparams.
  - NUM_REQ default.
  - packet_t typedef (logic [PACKET_WIDTH-1:0]).
- Sub-module noc_rr_picker:
  - Purely combinational circular priority search.
  - Inputs: eligible vector, rr_ptr. Outputs: one-hot gnt, granted index, any_gnt.
  - The pointer register stays in noc_output_arbiter.

Test Plan:
- Reset release: hold reset=0 with req=4'b1111 -> gnt=0, so=0, do=0. Release and toggle polarity -> first grant is index 0.
- Single packet, VC0 first-phase: req[1]=1 with 64'h200200000000FA50, polarity=0 at edge k, ro=1 -> gnt=4'b0010 at edge k; so=1, do=64'h200200000000FA50 after edge k+1 (polarity=1); so=0 after edge k+2.
- Round-robin: req=4'b1011, all VC0, polarity toggling, ro=1 -> VC0 grants across successive polarity-0 edges in order 0,1,3,0. No requester is granted twice before the others are served.
- VC separation: req0 = VC1 packet 64'hA00200000000FA50, req2 = VC0 packet.
  - polarity=0 -> only gnt[2].
  - Next edge polarity=1 -> gnt[0], and so=1 carrying the VC0 packet.
- Backpressure: buffer VC1 full, ro=0 for 5 drain phases -> so stays 0, a VC1 requester is never granted, VC0 traffic continues. With ARB_PERF_CNT_EN, stall_cnt=5. Raise ro -> packet sent on the next drain phase.
- Reset mid-operation: both buffers full, pull reset low between edges -> so=0 immediately; after release no stale packet is emitted and pkt_cnt=0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC defaults, VC encoding and packet type
package noc_pkg;

  localparam int PACKET_WIDTH = 64;
  localparam int NUM_REQ      = 4;
  localparam int VC_BIT       = PACKET_WIDTH - 1;

  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  typedef logic [PACKET_WIDTH-1:0] packet_t;

  function automatic logic packet_vc(input packet_t pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/noc_rr_picker.sv
// rtl/noc_rr_picker.sv - combinational circular priority search starting after rr_ptr
module noc_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any_gnt
);

  always_comb begin
    gnt     = '0;
    gnt_idx = rr_ptr;
    any_gnt = 1'b0;
    // Offsets 1..NUM_REQ visit rr_ptr+1 first and the last winner last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!any_gnt && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        any_gnt = 1'b1;
        gnt_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    if (any_gnt) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - polarity-phased round-robin output scheduler with per-VC buffers
// Optional ARB_PERF_CNT_EN adds saturating pkt_cnt/stall_cnt outputs.
module noc_output_arbiter #(
  parameter int NUM_REQ      = noc_pkg::NUM_REQ,
  parameter int PACKET_WIDTH = noc_pkg::PACKET_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            polarity,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]              gnt,
  input  logic                            ro,
  output logic                            so,
  output logic [PACKET_WIDTH-1:0]         do_data
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]                     pkt_cnt,
  output logic [15:0]                     stall_cnt
`endif
);
  import noc_pkg::*;

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int VC_MSB = PACKET_WIDTH - 1;

  logic [1:0]              buf_full;
  logic [PACKET_WIDTH-1:0] buf_data [2];
  logic [IDX_W-1:0]        rr_ptr;

  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    any_gnt;
  logic [PACKET_WIDTH-1:0] pick_pkt;
  logic                    fill_vc;
  logic                    drain_vc;
  logic                    drain_go;

  assign fill_vc  = polarity ? VC1 : VC0;
  assign drain_vc = ~fill_vc;
  assign drain_go = buf_full[drain_vc] & ro;

  // Gating with reset keeps gnt low while the block is held in reset.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = reset & req[i] & ~buf_full[fill_vc]
                  & (req_data[i*PACKET_WIDTH + VC_MSB] == fill_vc);
    end
  end

  noc_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .gnt      (pick_gnt),
    .gnt_idx  (pick_idx),
    .any_gnt  (any_gnt)
  );

  assign gnt      = pick_gnt;
  assign pick_pkt = req_data[int'(pick_idx)*PACKET_WIDTH +: PACKET_WIDTH];

  // Fill and drain always address opposite buffers, so both may update on one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full    <= '0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      rr_ptr      <= IDX_W'(NUM_REQ - 1);
      so          <= 1'b0;
      do_data     <= '0;
    end else begin
      so <= drain_go;
      if (drain_go) begin
        do_data            <= buf_data[drain_vc];
        buf_full[drain_vc] <= 1'b0;
      end
      if (any_gnt) begin
        buf_data[fill_vc] <= pick_pkt;
        buf_full[fill_vc] <= 1'b1;
        rr_ptr            <= pick_idx;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic stall;
  assign stall = buf_full[drain_vc] & ~ro;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (drain_go && pkt_cnt != 16'hFFFF) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (stall && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - table-driven directed bench for noc_output_arbiter
module tb_noc_output_arbiter;

  localparam int N = 4;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           polarity = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic           ro = 1'b1;
  logic           so;
  logic [W-1:0]   do_data;
`ifdef ARB_PERF_CNT_EN
  logic [15:0]    pkt_cnt;
  logic [15:0]    stall_cnt;
`endif

  noc_output_arbiter #(.NUM_REQ(N), .PACKET_WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .ro       (ro),
    .so       (so),
`ifdef ARB_PERF_CNT_EN
    .pkt_cnt  (pkt_cnt),
    .stall_cnt(stall_cnt),
`endif
    .do_data  (do_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         pol;
    logic [3:0]   req;
    logic [3:0]   vc;
    logic         ro;
    logic [3:0]   exp_gnt;
    logic         exp_so;
    logic [63:0]  exp_do;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [63:0] pkt(input int i, input logic vc);
    logic [63:0] base;
    base = vc ? 64'hA00200000000FA50 : 64'h200200000000FA50;
    return base + 64'(i);
  endfunction

  task automatic add(input logic rst, input logic pol, input logic [3:0] rq, input logic [3:0] vc,
                     input logic r, input logic [3:0] eg, input logic es, input logic [63:0] ed);
    vec_t v;
    v.rst = rst; v.pol = pol; v.req = rq; v.vc = vc; v.ro = r;
    v.exp_gnt = eg; v.exp_so = es; v.exp_do = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [3:0] rq, input logic [3:0] vc);
    req = rq;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = pkt(i, vc[i]);
  endtask

  initial begin
    // rst pol req vc ro | gnt so do
    add(0, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 64'h0);
    add(1, 0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 64'h0);
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, pkt(0, 0));
    add(1, 0, 4'b0010, 4'b0000, 1, 4'b0010, 0, pkt(0, 0));
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, pkt(1, 0));
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 0, pkt(1, 0));
    add(1, 0, 4'b1011, 4'b0000, 1, 4'b1000, 0, pkt(1, 0));
    add(1, 1, 4'b1011, 4'b0000, 1, 4'b0000, 1, pkt(3, 0));
    add(1, 0, 4'b1011, 4'b0000, 1, 4'b0001, 0, pkt(3, 0));
    add(1, 1, 4'b1011, 4'b0000, 1, 4'b0000, 1, pkt(0, 0));
    add(1, 0, 4'b1011, 4'b0000, 1, 4'b0010, 0, pkt(0, 0));
    add(1, 1, 4'b1011, 4'b0000, 1, 4'b0000, 1, pkt(1, 0));
    add(1, 0, 4'b1011, 4'b0000, 1, 4'b1000, 0, pkt(1, 0));
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, pkt(3, 0));
    add(1, 0, 4'b0101, 4'b0001, 1, 4'b0100, 0, pkt(3, 0));
    add(1, 1, 4'b0001, 4'b0001, 1, 4'b0001, 1, pkt(2, 0));
    add(1, 0, 4'b0000, 4'b0000, 1, 4'b0000, 1, pkt(0, 1));
    add(1, 1, 4'b0010, 4'b0010, 1, 4'b0010, 0, pkt(0, 1));
    add(1, 0, 4'b1100, 4'b0100, 0, 4'b1000, 0, pkt(0, 1));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 1, pkt(3, 0));
    add(1, 0, 4'b0100, 4'b0100, 0, 4'b0000, 0, pkt(3, 0));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, pkt(3, 0));
    add(1, 0, 4'b1100, 4'b0100, 0, 4'b1000, 0, pkt(3, 0));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 1, pkt(3, 0));
    add(1, 0, 4'b0100, 4'b0100, 0, 4'b0000, 0, pkt(3, 0));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, pkt(3, 0));
    add(1, 0, 4'b0100, 4'b0100, 0, 4'b0000, 0, pkt(3, 0));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0000, 0, pkt(3, 0));
    add(1, 0, 4'b0100, 4'b0100, 1, 4'b0000, 1, pkt(1, 1));
    add(1, 1, 4'b0100, 4'b0100, 1, 4'b0100, 0, pkt(1, 1));
    add(1, 0, 4'b0001, 4'b0000, 0, 4'b0001, 0, pkt(1, 1));
    add(1, 1, 4'b0000, 4'b0000, 1, 4'b0000, 1, pkt(0, 0));

    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge clk);
      reset    = vecs[v].rst;
      polarity = vecs[v].pol;
      ro       = vecs[v].ro;
      drive(vecs[v].req, vecs[v].vc);
      #1;
      check($sformatf("v%0d_gnt", v), 64'(gnt), 64'(vecs[v].exp_gnt));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_so", v), 64'(so), 64'(vecs[v].exp_so));
      check($sformatf("v%0d_do", v), do_data, vecs[v].exp_do);
`ifdef ARB_PERF_CNT_EN
      if (v == 26) check("stall_cnt_after_backpressure", 64'(stall_cnt), 64'd5);
`endif
    end

    // Asynchronous reset between edges while a packet is on the wire and VC1 still holds one.
    polarity = 1'b0;
    drive(4'b1111, 4'b0000);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_so", 64'(so), 64'd0);
    check("async_rst_do", do_data, 64'h0);
    check("async_rst_gnt", 64'(gnt), 64'd0);
`ifdef ARB_PERF_CNT_EN
    check("async_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    @(negedge clk);
    reset = 1'b1;
    ro    = 1'b1;
    drive(4'b0000, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      polarity = ~polarity;
      @(posedge clk);
      #1;
      check($sformatf("no_stale_so_c%0d", c), 64'(so), 64'd0);
    end

    @(negedge clk);
    polarity = 1'b0;
    drive(4'b1111, 4'b0000);
    #1;
    check("post_rst_first_gnt", 64'(gnt), 64'b0001);
    @(posedge clk);
    #1;
    @(negedge clk);
    polarity = 1'b1;
    drive(4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    check("post_rst_so", 64'(so), 64'd1);
    check("post_rst_do", do_data, pkt(0, 0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
